// File: rtl/serial_add_pkg.sv
// Shared types for the serial 2-bit-per-cycle adder controller.
package serial_add_pkg;
  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/serial_add_ctrl_adder2.sv
// 2-bit full-adder slice: {co, s} = a + b + ci.
module adder2 (
  input  logic [1:0] a,
  input  logic [1:0] b,
  input  logic       ci,
  output logic [1:0] s,
  output logic       co
);
  assign {co, s} = {1'b0, a} + {1'b0, b} + {2'b00, ci};
endmodule

// File: rtl/serial_add_ctrl.sv
// Serial adder: accepts A, B, c_in, then resolves two bits per cycle through
// one adder2 slice, presenting sum/c_out with a valid/ready handshake.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);
  localparam int CNT_W = (WIDTH / 2 > 1) ? $clog2(WIDTH / 2) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH / 2 - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic [1:0]       slice_s;
  logic             slice_co;

  adder2 u_slice (
    .a  (a_q[1:0]),
    .b  (b_q[1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .co (slice_co)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // New slice bits enter at the MSB so the LSB slice ends up at bit 0.
        sum_d   = WIDTH'({slice_s, sum_q} >> 2);
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        carry_d = slice_co;
        if (cnt_q == CNT_LAST) begin
          cout_d  = slice_co;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign sum   = sum_q;
  assign c_out = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl against a plain-arithmetic model.
module tb_serial_add_ctrl;
  localparam int W = 8;
  localparam int LAT = W / 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, out_valid, out_ready, c_in, c_out;
  logic [W-1:0] a, b, sum;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: (W+1)-bit sum of the operands and carry.
  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  // Waits (bounded) for out_valid; returns cycles counted from the accept edge.
  task automatic wait_valid(input bit toggle, output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (toggle) begin
        check("in_ready_busy", 32'(in_ready), 32'd0);
        in_valid = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
        c_in = 1'($urandom);
      end
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
  endtask

  // One complete transaction: accept, compute, hold in DONE, hand off.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input bit rdy_run, input int hold, input bit toggle, input bit full);
    logic [W:0]   exp;
    logic [W-1:0] held;
    int           lat;
    exp = ref_add(x, y, ci);
    if (full) check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1; a = x; b = y; c_in = ci;
    out_ready = rdy_run;
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(toggle, lat);
    if (full) check("latency", 32'(lat), 32'(LAT));
    check("sum", 32'(sum), 32'(exp[W-1:0]));
    check("c_out", 32'(c_out), 32'(exp[W]));
    held = sum;
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(sum), 32'(held));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    if (full) begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_ready", 32'(in_ready), 32'd1);
    end
  endtask

  initial begin
    logic [W:0] e1, e2;
    int         lat;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; c_in = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Overflow wrap with out_ready already high during RUN.
    run_op(8'hFF, 8'h01, 1'b0, 1'b1, 0, 1'b0, 1'b1);
    // Stall in DONE for 5 cycles.
    run_op(8'h5A, 8'h3C, 1'b1, 1'b0, 5, 1'b0, 1'b1);
    // Noise on in_valid/operands while busy.
    run_op(8'hC3, 8'h7E, 1'b1, 1'b0, 1, 1'b1, 1'b1);

    // Asynchronous reset mid-RUN.
    in_valid = 1'b1; a = 8'hAB; b = 8'hCD; c_in = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd1);
    check("arst_sum", 32'(sum), 32'd0);
    check("arst_c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("post_rst_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1'b0, 1'b1);

    // Back-to-back with in_valid held high throughout.
    e1 = ref_add(8'h80, 8'h80, 1'b0);
    e2 = ref_add(8'h01, 8'h02, 1'b0);
    in_valid = 1'b1; a = 8'h80; b = 8'h80; c_in = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    a = 8'h01; b = 8'h02;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("b2b_lat1", 32'(lat), 32'(LAT));
    check("b2b_sum1", 32'(sum), 32'(e1[W-1:0]));
    check("b2b_cout1", 32'(c_out), 32'(e1[W]));
    @(negedge clk);
    check("b2b_handoff_ready", 32'(in_ready), 32'd1);
    check("b2b_handoff_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("b2b_second_accept", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    wait_valid(1'b0, lat);
    check("b2b_lat2", 32'(lat), 32'(LAT));
    check("b2b_sum2", 32'(sum), 32'(e2[W-1:0]));
    check("b2b_cout2", 32'(c_out), 32'(e2[W]));
    @(negedge clk);
    out_ready = 1'b0;

    // Random operands with random handshake stalls.
    for (int n = 0; n < 1000; n++)
      run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 2)), 1'($urandom), (n % 50) == 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: operand width in bits; SHALL be even and >= 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  requester presents operands.
REQ-005 in_ready  output  1  controller can accept operands.
REQ-006 a  input  WIDTH  operand A.
REQ-007 b  input  WIDTH  operand B.
REQ-008 c_in  input  1  carry into bit 0.
REQ-009 out_valid  output  1  result available.
REQ-010 out_ready  input  1  consumer takes result.
REQ-011 sum  output  WIDTH  registered result A+B+c_in, modulo 2^WIDTH.
REQ-012 c_out  output  1  registered carry out of bit WIDTH-1.

Function
REQ-013 The block SHALL compute A+B+c_in serially, 2 bits per cycle, through one 2-bit adder slice with registered inter-slice carry.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid=1, the block SHALL latch a, b and c_in into the operand shift registers and carry flop, clear the slice counter, and enter RUN.
REQ-016 RUN: each cycle, the slice SHALL add operand bits [1:0] and the carry flop; at the edge the 2-bit result SHALL shift into sum from the MSB end, the operands SHALL shift right by 2, the carry flop SHALL take the slice carry, and the counter SHALL increment.
REQ-017 When the counter equals WIDTH/2-1 at an edge, the FSM SHALL go to DONE, and c_out SHALL equal the final slice carry.
REQ-018 Latency: out_valid SHALL rise exactly WIDTH/2 cycles after the accepting edge (4 for WIDTH=8).
REQ-019 DONE: out_valid=1; sum and c_out SHALL hold stable until out_ready=1, then the FSM SHALL return to IDLE on that edge.
REQ-020 in_ready SHALL be 0 in RUN and DONE; in_valid and operand changes there SHALL be ignored.
REQ-021 No new operands SHALL be accepted in the output-handoff cycle; the earliest next accept is the cycle after.
REQ-022 out_ready while not in DONE SHALL have no effect.
REQ-023 Arithmetic SHALL wrap modulo 2^WIDTH; overflow is reported only via c_out.
REQ-024 The counter width SHALL be max(1, clog2(WIDTH/2)), and the counter SHALL never exceed WIDTH/2-1.

Reset
REQ-025 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, sum=0, c_out=0, and clear the counter, operand registers and carry flop, regardless of clk.
REQ-026 Reset asserted in RUN or DONE SHALL abort the operation; no out_valid SHALL follow for it.
REQ-027 The first accept after reset SHALL be possible on the first rising edge with rst_n=1.

Structure
REQ-028 A shared package serial_add_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default width constant.
REQ-029 The datapath SHALL instantiate exactly one existing adder2 slice as its sub-module; no other adder logic is permitted.
REQ-030 The FSM, counter, shift registers and carry flop SHALL live in serial_add_ctrl.

Verification (WIDTH=8)
REQ-031 a=0xFF, b=0x01, c_in=0, accepted with out_ready=1 -> out_valid 4 cycles later, sum=0x00, c_out=1, then IDLE the next cycle.
REQ-032 a=0x5A, b=0x3C, c_in=1 -> sum=0x97, c_out=0; hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1 and sum stays constant.
REQ-033 Toggle in_valid and operands during RUN -> in_ready=0 and the result is unaffected.
REQ-034 Pulse rst_n low mid-RUN, asynchronously between edges -> outputs go to reset values at once, no out_valid follows, and the next accept works.
REQ-035 Back-to-back: a=0x80, b=0x80, c_in=0, then a=0x01, b=0x02, c_in=0 with in_valid held high -> results {0x00, c_out=1} then {0x03, c_out=0}, with the second accept one cycle after the first handoff.
REQ-036 Random operands (1000 cases) compared against a reference sum -> zero mismatches.
